// File: rtl/ifu_defs.sv
// Shared fetch-unit definitions: FSM encodings, reset PC, NOP word and IQ entry layout.
// Pure declarations; no timing or flow control of its own.
package ifu_defs;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [31:0] IFU_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_iq.sv
// Synchronous FIFO with flush and occupancy count; head is a registered entry, 1 cycle push->head.
// Push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module ifu_iq #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues IMEM word fetches, queues responses for the decoder; >=2 cycles accept->instr_valid.
// Requests are credit-limited so in-flight + queued words never exceed IQ_DEPTH; redirect flushes and drops stale words.
module instr_fetch_unit
  import ifu_defs::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          IQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instru,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] iq_count;
  logic [CW-1:0] tag_count;
  logic          iq_empty, iq_full, tag_empty, tag_full;
  iq_entry_t     iq_head, iq_wr;
  logic [31:0]   tag_pc;
  logic          accept, resp, redirect_eff, iq_push, iq_pop;

  assign redirect_eff   = redirect_valid && (state != S_BOOT);
  assign imem_req_valid = (state == S_RUN) && !halt &&
                          (({1'b0, outstanding} + {1'b0, iq_count}) < (CW+1)'(IQ_DEPTH));
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp           = imem_rvalid && (outstanding != '0);

  // A response is discarded while stale words are owed, and also in a redirect cycle itself.
  assign iq_push     = resp && (drop_cnt == '0) && !redirect_eff;
  assign iq_wr       = '{pc: tag_pc, instr: imem_rdata};
  assign instr_valid = !iq_empty && !redirect_valid;
  assign iq_pop      = instr_valid && instr_ready;
  assign instru      = iq_empty ? NOP_WORD : iq_head.instr;
  assign instr_pc    = iq_empty ? 32'h0    : iq_head.pc;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({accept, resp})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (halt) state <= S_HALT;
        S_HALT:  if (!halt) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
      outstanding <= outstanding_nxt;
      if (redirect_eff) begin
        fetch_pc <= word_align(redirect_pc);
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  ifu_iq #(.WIDTH(64), .DEPTH(IQ_DEPTH)) u_iq (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_eff),
    .push     (iq_push),
    .push_dat (iq_wr),
    .pop      (iq_pop),
    .head_dat (iq_head),
    .empty    (iq_empty),
    .full     (iq_full),
    .count    (iq_count)
  );

  // Tags are never flushed: stale responses still arrive and must pop their PC.
  ifu_iq #(.WIDTH(32), .DEPTH(IQ_DEPTH)) u_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push     (accept),
    .push_dat (fetch_pc),
    .pop      (resp),
    .head_dat (tag_pc),
    .empty    (tag_empty),
    .full     (tag_full),
    .count    (tag_count)
  );

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding == '0)));
  a_iq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(iq_push && iq_full && !iq_pop));
  a_tag_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp && tag_empty) && !(accept && tag_full) && (tag_count == outstanding));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: IMEM model with programmable latency, decoder log checked
// against hand-computed PC sequences (instruction word = ~pc).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instru;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  int n_acc    = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instru         (instru),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Observe handshakes mid-cycle, then drive the IMEM response for the next cycle.
  task automatic cycle();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
      n_acc++;
    end
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_ins.push_back(instru);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~mq_addr[0];
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_log(input string tag, input logic [31:0] base, input int exp_n);
    logic [31:0] pc;
    check_eq({tag, "_count"}, 32'(got_pc.size()), 32'(exp_n));
    for (int i = 0; i < got_pc.size(); i++) begin
      pc = base + 32'(4 * i);
      check_eq({tag, "_pc"}, got_pc[i], pc);
      check_eq({tag, "_ins"}, got_ins[i], ~pc);
    end
    got_pc.delete();
    got_ins.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;

    // Reset values
    run(3);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0040_0000);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instru", instru, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("boot_req_valid", 32'(imem_req_valid), 32'd0);
    run(1);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_addr, 32'h0040_0000);

    // Stream, then decoder backpressure
    run(12);
    instr_ready = 1'b0;
    run(8);
    check_eq("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("bp_instr_valid", 32'(instr_valid), 32'd1);
    check_eq("bp_buffered", 32'(n_acc - got_pc.size()), 32'd2);
    instr_ready = 1'b1;
    halt        = 1'b1;
    run(10);
    check_eq("drain_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("drain_instr_valid", 32'(instr_valid), 32'd0);
    check_log("stream", 32'h0040_0000, n_acc);

    // Redirect with two requests in flight
    lat  = 3;
    halt = 1'b0;
    run(3);
    check_eq("r4_credit_block", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0100;
    #1;
    check_eq("r4_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    n_acc = 0;
    check_eq("r4_addr", imem_addr, 32'h0040_0100);
    check_eq("r4_req_after", 32'(imem_req_valid), 32'd0);
    run(14);
    halt = 1'b1;
    run(10);
    check_log("r4", 32'h0040_0100, n_acc);

    // Redirect coinciding with a response and a new accept
    lat  = 1;
    halt = 1'b0;
    run(2);
    check_eq("r5_req_valid", 32'(imem_req_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0203;
    cycle();
    redirect_valid = 1'b0;
    n_acc = 0;
    check_eq("r5_addr", imem_addr, 32'h0040_0200);
    check_eq("r5_req_after", 32'(imem_req_valid), 32'd1);
    run(12);
    halt = 1'b1;
    run(10);
    check_log("r5", 32'h0040_0200, n_acc);

    // Halt: redirect while halted, in-flight delivery, then wrap-around fetch
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0300;
    cycle();
    redirect_valid = 1'b0;
    n_acc = 0;
    check_eq("h6_addr", imem_addr, 32'h0040_0300);
    check_eq("h6_req_halted", 32'(imem_req_valid), 32'd0);
    halt = 1'b0;
    run(6);
    halt        = 1'b1;
    instr_ready = 1'b0;
    #1;
    check_eq("h6_req_off", 32'(imem_req_valid), 32'd0);
    run(3);
    check_eq("h6_instr_valid", 32'(instr_valid), 32'd1);
    check_eq("h6_instr_pc", instr_pc, 32'h0040_0308);
    check_eq("h6_instru", instru, ~32'h0040_0308);
    check_eq("h6_acc", 32'(n_acc), 32'd4);
    check_log("h6", 32'h0040_0300, 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    #1;
    check_eq("wrap_rd_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    n_acc = 0;
    check_eq("wrap_flushed", 32'(instr_valid), 32'd0);
    check_eq("wrap_addr_halted", imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_req_halted", 32'(imem_req_valid), 32'd0);
    halt        = 1'b0;
    instr_ready = 1'b1;
    run(1);
    check_eq("wrap_req", 32'(imem_req_valid), 32'd1);
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    run(1);
    check_eq("wrap_addr1", imem_addr, 32'h0000_0000);
    run(8);
    halt = 1'b1;
    run(10);
    check_log("wrap", 32'hFFFF_FFFC, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
